// File: rtl/dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : dm_resp
// Purpose  : Data-memory responder. Accepts one load/store request at a time,
//            performs a byte/halfword/word access on an internal word array
//            after LATENCY cycles and returns extended load data or an error
//            flag over a valid/ready response handshake.
// Ports    : clk, rstn           - clock, asynchronous active-low reset
//            req_valid/req_ready - request handshake (ready only when idle)
//            req_we              - 1 = store, 0 = load
//            req_addr            - byte address
//            req_wdata           - right-aligned store data
//            req_wtype           - store type 1111 word, 0011 half, 0001 byte
//            req_rtype           - load type 000 w, 001 h, 010 hu, 011 b, 100 bu
//            resp_valid/ready    - response handshake
//            resp_rdata          - extended load data (0 for stores / errors)
//            resp_err            - misaligned, out-of-range or illegal type
// Revision : 1.0 - initial release
// ============================================================================
module dm_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wtype,
    input  logic [2:0]  req_rtype,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          c_idx_w    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth    = 32'(DEPTH_WORDS);
    localparam logic [3:0]  c_cnt_init = 4'(LATENCY - 1);
    localparam bit          c_lat_one  = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_err, w_err_nxt;

    logic        w_accept;
    logic        w_do_access;

    // Request fields as seen by the access logic
    logic        w_a_we;
    logic [31:0] w_a_addr;
    logic [31:0] w_a_wdata;
    logic [3:0]  w_a_wtype;
    logic [2:0]  w_a_rtype;

    logic [31:0] r_mem [DEPTH_WORDS];

    // Requests are ignored while reset is asserted, even though req_ready is
    // decoded high from IDLE.
    assign w_accept   = req_valid && req_ready && rstn;
    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // With a single-cycle latency the access happens on the acceptance edge,
    // so it must use the live request; otherwise the captured copy is used.
    generate
        if (c_lat_one) begin : g_lat_one
            assign w_a_we    = req_we;
            assign w_a_addr  = req_addr;
            assign w_a_wdata = req_wdata;
            assign w_a_wtype = req_wtype;
            assign w_a_rtype = req_rtype;
        end else begin : g_lat_multi
            logic        r_we;
            logic [31:0] r_addr;
            logic [31:0] r_wdata;
            logic [3:0]  r_wtype;
            logic [2:0]  r_rtype;

            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_wtype <= req_wtype;
                    r_rtype <= req_rtype;
                end
            end

            assign w_a_we    = r_we;
            assign w_a_addr  = r_addr;
            assign w_a_wdata = r_wdata;
            assign w_a_wtype = r_wtype;
            assign w_a_rtype = r_rtype;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic [1:0]         w_lane;
    logic [c_idx_w-1:0] w_idx;
    logic               w_size_word, w_size_half, w_type_ok, w_range_ok, w_misal;
    logic               w_err;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rword;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ld_data;

    assign w_lane  = w_a_addr[1:0];
    assign w_idx   = w_a_addr[c_idx_w+1:2];
    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
    assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
    assign w_be    = w_a_wtype << w_lane;

    always_comb begin
        w_size_word = 1'b0;
        w_size_half = 1'b0;
        w_type_ok   = 1'b0;
        w_wdata_rep = w_a_wdata;
        w_ld_data   = 32'd0;

        if (w_a_we) begin
            case (w_a_wtype)
                4'b1111: begin w_size_word = 1'b1; w_type_ok = 1'b1; end
                4'b0011: begin w_size_half = 1'b1; w_type_ok = 1'b1;
                               w_wdata_rep = {2{w_a_wdata[15:0]}}; end
                4'b0001: begin w_type_ok = 1'b1;
                               w_wdata_rep = {4{w_a_wdata[7:0]}}; end
                default: w_type_ok = 1'b0;
            endcase
        end else begin
            case (w_a_rtype)
                3'b000: begin w_size_word = 1'b1; w_type_ok = 1'b1;
                              w_ld_data = w_rword; end
                3'b001: begin w_size_half = 1'b1; w_type_ok = 1'b1;
                              w_ld_data = {{16{w_half[15]}}, w_half}; end
                3'b010: begin w_size_half = 1'b1; w_type_ok = 1'b1;
                              w_ld_data = {16'd0, w_half}; end
                3'b011: begin w_type_ok = 1'b1;
                              w_ld_data = {{24{w_byte[7]}}, w_byte}; end
                3'b100: begin w_type_ok = 1'b1;
                              w_ld_data = {24'd0, w_byte}; end
                default: w_type_ok = 1'b0;
            endcase
        end

        w_range_ok = ({2'b00, w_a_addr[31:2]} < c_depth);
        w_misal    = (w_size_word && (w_lane != 2'd0)) || (w_size_half && w_lane[0]);
        w_err      = !w_range_ok || w_misal || !w_type_ok;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_do_access = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (c_lat_one) begin
                        w_do_access = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = c_cnt_init;
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_do_access = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_do_access) begin
            w_err_nxt   = w_err;
            w_rdata_nxt = (w_err || w_a_we) ? 32'd0 : w_ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Word array (not reset). Only enabled byte lanes are written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_do_access && w_a_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_resp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dm_resp
// Purpose  : Self-checking bench for dm_resp. Three instances with LATENCY
//            2, 4 and 1 share one clock. A byte-array reference model
//            supplies expected values for randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_resp;

    localparam int DEPTH = 1024;
    localparam int NI    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0]        rstn, req_valid, req_ready, req_we;
    logic [NI-1:0]        resp_valid, resp_ready, resp_err;
    logic [NI-1:0][31:0]  req_addr, req_wdata, resp_rdata;
    logic [NI-1:0][3:0]   req_wtype;
    logic [NI-1:0][2:0]   req_rtype;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            dm_resp #(
                .DEPTH_WORDS (DEPTH),
                .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
            ) u_dut (
                .clk        (clk),
                .rstn       (rstn[g]),
                .req_valid  (req_valid[g]),
                .req_ready  (req_ready[g]),
                .req_we     (req_we[g]),
                .req_addr   (req_addr[g]),
                .req_wdata  (req_wdata[g]),
                .req_wtype  (req_wtype[g]),
                .req_rtype  (req_rtype[g]),
                .resp_valid (resp_valid[g]),
                .resp_ready (resp_ready[g]),
                .resp_rdata (resp_rdata[g]),
                .resp_err   (resp_err[g])
            );
        end
    endgenerate

    int n_vec = 0;
    int n_bad = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: flat byte memory per instance -------
    logic [7:0] mdl [NI][DEPTH*4];

    function automatic void model(input int k, input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] wt,
                                  input logic [2:0] rt,
                                  output logic [31:0] rd, output logic er);
        int nb;
        bit sgn;
        logic [31:0] val;
        nb  = 0;
        sgn = 0;
        if (we) begin
            if (wt == 4'hF) nb = 4;
            else if (wt == 4'h3) nb = 2;
            else if (wt == 4'h1) nb = 1;
        end else begin
            case (rt)
                3'd0: nb = 4;
                3'd1: begin nb = 2; sgn = 1; end
                3'd2: nb = 2;
                3'd3: begin nb = 1; sgn = 1; end
                3'd4: nb = 1;
                default: nb = 0;
            endcase
        end
        er = (nb == 0) || ((a / 4) >= DEPTH) || ((a % nb) != 0);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[k][int'(a) + i] = 8'(wd >> (8 * i));
            end else begin
                val = 32'd0;
                for (int i = 0; i < nb; i++) val = val | (32'(mdl[k][int'(a) + i]) << (8 * i));
                if (sgn && val[8*nb-1]) val = val - (32'd1 << (8 * nb));
                rd = val;
            end
        end
    endfunction

    // ---------------- one transaction with optional response backpressure --
    task automatic txn(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wt, input logic [2:0] rt, input int hold,
                       output logic [31:0] rd, output logic er, output int acc);
        int n;
        rd  = 'x;
        er  = 1'bx;
        acc = cyc;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready[k]) begin
            chk("req_ready_wait", {31'd0, req_ready[k]}, 32'd1);
            return;
        end
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_addr[k]   = a;
        req_wdata[k]  = wd;
        req_wtype[k]  = wt;
        req_rtype[k]  = rt;
        resp_ready[k] = (hold == 0);
        @(posedge clk); #1;
        acc = cyc;
        // Scramble request inputs: only the acceptance edge may sample them.
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_wtype[k] = 4'($urandom);
        req_rtype[k] = 3'($urandom);
        n = 1;
        while (!resp_valid[k] && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(lat_of(k)));
        if (!resp_valid[k]) return;
        rd = resp_rdata[k];
        er = resp_err[k];
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("bp_valid", {31'd0, resp_valid[k]}, 32'd1);
                chk("bp_rdata", resp_rdata[k], rd);
                chk("bp_err", {31'd0, resp_err[k]}, {31'd0, er});
                chk("bp_req_ready", {31'd0, req_ready[k]}, 32'd0);
            end
            resp_ready[k] = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        chk("ready_after_resp", {31'd0, req_ready[k]}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  wt;
        logic [2:0]  rt;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, m_rd;
        logic        er, m_er;
        int          acc0, acc1;
        logic        we;
        logic [31:0] a, wd;
        logic [3:0]  wt;
        logic [2:0]  rt;

        // Directed table for the LATENCY=2 instance
        tbl.push_back('{1'b1, 32'h10,  32'h12345678, 4'hF, 3'd0, 0, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 32'h11,  32'h0,        4'h0, 3'd3, 0, 32'h00000056, 1'b0});
        tbl.push_back('{1'b0, 32'h13,  32'h0,        4'h0, 3'd4, 0, 32'h00000012, 1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 3'd0, 0, 32'h12345678, 1'b0});
        tbl.push_back('{1'b1, 32'h12,  32'h80,       4'h1, 3'd0, 0, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 32'h12,  32'h0,        4'h0, 3'd3, 0, 32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 32'h12,  32'h0,        4'h0, 3'd4, 0, 32'h00000080, 1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 3'd0, 0, 32'h12805678, 1'b0});
        tbl.push_back('{1'b1, 32'h12,  32'hBEEF,     4'h3, 3'd0, 0, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 32'h12,  32'h0,        4'h0, 3'd1, 0, 32'hFFFFBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h12,  32'h0,        4'h0, 3'd2, 0, 32'h0000BEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 3'd0, 0, 32'hBEEF5678, 1'b0});
        tbl.push_back('{1'b0, 32'h11,  32'h0,        4'h0, 3'd0, 0, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 32'h13,  32'hAAAA,     4'h3, 3'd0, 0, 32'h00000000, 1'b1});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 3'd0, 3, 32'hBEEF5678, 1'b0});
        tbl.push_back('{1'b0, 32'h1000, 32'h0,       4'h0, 3'd0, 0, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 32'h14,  32'h55555555, 4'h7, 3'd0, 0, 32'h00000000, 1'b1});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 3'd5, 0, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 32'hFFC, 32'hA5A55A5A, 4'hF, 3'd0, 1, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 32'hFFC, 32'h0,        4'h0, 3'd0, 0, 32'hA5A55A5A, 1'b0});

        // Reset with requests presented: they must be ignored
        rstn       = '0;
        req_valid  = '1;
        req_we     = '1;
        req_addr   = '0;
        req_wdata  = {NI{32'hDEADBEEF}};
        req_wtype  = {NI{4'hF}};
        req_rtype  = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst%0d_resp_valid", k), {31'd0, resp_valid[k]}, 32'd0);
            chk($sformatf("rst%0d_req_ready", k),  {31'd0, req_ready[k]},  32'd1);
            chk($sformatf("rst%0d_rdata", k),      resp_rdata[k],          32'd0);
            chk($sformatf("rst%0d_err", k),        {31'd0, resp_err[k]},   32'd0);
        end
        req_valid = '0;
        @(posedge clk); #1;
        rstn = '1;
        @(posedge clk); #1;

        // Table-driven directed vectors
        for (int i = 0; i < tbl.size(); i++) begin
            txn(0, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].wt, tbl[i].rt, tbl[i].hold, rd, er, acc0);
            model(0, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].wt, tbl[i].rt, m_rd, m_er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_er});
        end

        // Reset in the middle of BUSY drops the pending store (LATENCY=4)
        txn(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, 3'd0, 0, rd, er, acc0);
        chk("rm_pre_store_err", {31'd0, er}, 32'd0);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'hFFFFFFFF;
        req_wtype[1] = 4'hF;
        req_rtype[1] = 3'd0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("rm_busy_req_ready", {31'd0, req_ready[1]}, 32'd0);
        rstn[1] = 1'b0;
        #1;
        chk("rm_async_req_ready", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("rm_no_resp", {31'd0, resp_valid[1]}, 32'd0);
        end
        chk("rm_idle", {31'd0, req_ready[1]}, 32'd1);
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'd0, 0, rd, er, acc0);
        chk("rm_load_unchanged", rd, 32'h0BADF00D);

        // LATENCY=1 back-to-back store then load
        txn(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'd0, 0, rd, er, acc0);
        txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 3'd0, 0, rd, er, acc1);
        chk("l1_load", rd, 32'hCAFEF00D);
        chk("l1_accept_spacing", 32'(acc1 - acc0), 32'd2);

        // Randomized traffic against the model: prefill a window, then mix
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            txn(0, 1'b1, 32'(w * 4), wd, 4'hF, 3'd0, 0, rd, er, acc0);
            model(0, 1'b1, 32'(w * 4), wd, 4'hF, 3'd0, m_rd, m_er);
            chk("fill_err", {31'd0, er}, {31'd0, m_er});
        end
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            wd = $urandom;
            case ($urandom_range(0, 4))
                0:       wt = 4'hF;
                1:       wt = 4'h3;
                2:       wt = 4'h1;
                3:       wt = 4'($urandom);
                default: wt = 4'hF;
            endcase
            rt = 3'($urandom_range(0, 7));
            txn(0, we, a, wd, wt, rt, $urandom_range(0, 2), rd, er, acc0);
            model(0, we, a, wd, wt, rt, m_rd, m_er);
            chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
            chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, m_er});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder at the far end of the load/store control path.
- Consumes the store byte-enable type and the load type that the instruction decoder emits, together with the address and store data.
- Performs the byte, halfword or word access on an internal word array after a fixed, parameterised latency.
- Returns sign- or zero-extended load data, or an error flag, over a valid/ready response handshake. Only one transaction is outstanding at a time.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Valid word index is addr[31:2] < DEPTH_WORDS.
- LATENCY, 2: cycles from request acceptance to resp_valid. Legal range is 1..15.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder idle and able to accept
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_wtype  input  4  store type: 1111 word, 0011 half, 0001 byte
- req_rtype  input  3  load type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned, out-of-range or illegal type

Behaviour:
- Reset:
  - rstn low asynchronously forces state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
  - req_ready is 1 because it is decoded from IDLE, but requests are ignored while rstn is low.
  - Array contents are not reset.
- States: IDLE, BUSY, RESP. req_ready = (state == IDLE). resp_valid = (state == RESP).
- IDLE:
  - On the edge where req_valid & req_ready, capture we/addr/wdata/wtype/rtype into request registers.
  - If LATENCY == 1, go to RESP and perform the access at this same edge.
  - Otherwise load cnt = LATENCY-1 and go to BUSY.
- BUSY:
  - Each edge, cnt decrements.
  - At the edge where cnt == 1: perform the access, latch resp_rdata/resp_err, go to RESP.
  - Net effect: for an acceptance edge E0, resp_valid rises exactly LATENCY cycles after E0.
- RESP:
  - Hold resp_valid, resp_rdata and resp_err stable while resp_ready is low.
  - On the edge where resp_valid & resp_ready, go to IDLE.
  - The earliest next acceptance is on the following edge; no acceptance happens in the same cycle as a response.
- Access rules (lane = addr[1:0]):
  - Error conditions:
    - word access with lane != 0
    - halfword access with addr[0] == 1
    - addr[31:2] >= DEPTH_WORDS
    - store with a wtype outside {1111, 0011, 0001}
    - load with rtype in 101..111
  - On error: no array write, resp_err = 1, resp_rdata = 0.
- Store:
  - Byte enables = wtype << lane.
  - Write data is replicated: byte → {4{wdata[7:0]}}, half → {2{wdata[15:0]}}, word → wdata.
  - Only enabled bytes change. resp_rdata = 0, resp_err = 0.
- Load:
  - Read the word, select the byte at lane or the half at lane[1], then extend.
  - Sign-extend for 001 and 011; zero-extend for 010 and 100.
- Ordering: with one outstanding transaction, a load accepted after a store's response always observes that store.
- Inputs are sampled only on the acceptance edge; changes while BUSY or RESP have no effect.
- Reset mid-BUSY or mid-RESP: the pending transaction is dropped. An access not yet performed never occurs, and the array is left as it was. After release the block is IDLE.

Test Plan:
- LATENCY=2; sw 0x12345678 @0x10 accepted at edge 0 → resp_valid high from cycle 2, err 0. Then lb @0x11 → 0x00000056; lbu @0x13 → 0x00000012; lw @0x10 → 0x12345678.
- sb 0x80 @0x12 → lb @0x12 = 0xFFFFFF80, lbu = 0x00000080, lw @0x10 = 0x12805678. Then sh 0xBEEF @0x12 → lh = 0xFFFFBEEF, lhu = 0x0000BEEF, lw = 0xBEEF5678.
- Misaligned and out-of-range:
  - lw @0x11 → resp_err 1, rdata 0.
  - sh 0xAAAA @0x13 → resp_err 1; subsequent lw @0x10 is unchanged.
  - lw @(DEPTH_WORDS*4) → resp_err 1.
- Backpressure: hold resp_ready low for 3 cycles during a load response → resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0. Raising resp_ready returns the block to IDLE; req_ready is 1 in the next cycle.
- Reset mid-op: LATENCY=4; sw 0xFFFFFFFF @0x20 accepted, then pulse rstn low for one cycle in the first BUSY cycle → resp_valid 0, req_ready 1 after release, lw @0x20 returns the pre-store value.
- LATENCY=1; back-to-back sw then lw with resp_ready tied 1 → each resp_valid one cycle after acceptance. Accepts occur every 2 cycles, and the lw returns the stored word.
